// File: rtl/ysyx_22040931_store_unit_pkg.sv
// Shared constants for the memory-stage store unit: width codes, FSM encoding,
// AXI response code and the lane-alignment result payload.
package ysyx_22040931_store_unit_pkg;

  localparam int unsigned BUS_DATA_W = 64;
  localparam int unsigned BUS_STRB_W = BUS_DATA_W / 8;

  localparam logic [2:0] W_ONE = 3'b001;
  localparam logic [2:0] W_DOU = 3'b010;
  localparam logic [2:0] W_FOR = 3'b011;
  localparam logic [2:0] W_EIG = 3'b100;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef struct packed {
    logic [BUS_DATA_W-1:0] wdata;
    logic [BUS_STRB_W-1:0] wstrb;
    logic                  misalign;
  } align_t;

  function automatic logic is_store(input logic [2:0] op);
    return (op == W_ONE) || (op == W_DOU) || (op == W_FOR) || (op == W_EIG);
  endfunction

endpackage

// File: rtl/ysyx_22040931_store_unit_if.sv
// EX-side store request plus AXI4-Lite write channels of the store unit.
interface ysyx_22040931_store_unit_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_memwop;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_wdata;
  logic              done;
  logic              err;
  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;

  modport master (
    input  in_valid, in_memwop, in_addr, in_wdata, awready, wready, bvalid, bresp,
    output in_ready, done, err, awvalid, awaddr, wvalid, wdata, wstrb, bready
  );

  modport slave (
    output in_valid, in_memwop, in_addr, in_wdata, awready, wready, bvalid, bresp,
    input  in_ready, done, err, awvalid, awaddr, wvalid, wdata, wstrb, bready
  );
endinterface

// File: rtl/ysyx_22040931_store_unit_align.sv
// Steers LSB-justified store data onto its byte lanes and flags misaligned accesses.
module ysyx_22040931_store_align
  import ysyx_22040931_store_unit_pkg::*;
(
  input  logic [2:0]            memwop,
  input  logic [2:0]            off,
  input  logic [BUS_DATA_W-1:0] wdata,
  output align_t                align_c
);

  logic [BUS_STRB_W-1:0] base_strb;
  logic                  misalign;

  always_comb begin
    base_strb = '0;
    misalign  = 1'b0;
    case (memwop)
      W_ONE: base_strb = 8'h01;
      W_DOU: begin base_strb = 8'h03; misalign = off[0];          end
      W_FOR: begin base_strb = 8'h0F; misalign = (off[1:0] != 2'b00); end
      W_EIG: begin base_strb = 8'hFF; misalign = (off != 3'b000);     end
      default: ;
    endcase
    align_c.wdata    = wdata << {off, 3'b000};
    align_c.wstrb    = BUS_STRB_W'(base_strb << off);
    align_c.misalign = misalign;
  end

endmodule

// File: rtl/ysyx_22040931_store_unit.sv
// Memory-stage store executor: one store in, one AXI4-Lite write out, pipeline
// held via in_ready until the response retires it.
module ysyx_22040931_store_unit
  import ysyx_22040931_store_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input logic                          clk,
  input logic                          rst_n,
  ysyx_22040931_store_unit_if.master   bus
);

  localparam int unsigned STRB_W = DATA_W / 8;

  logic [1:0]        state_q,   state_d;
  logic              in_ready_q, in_ready_d;
  logic              done_q,    done_d;
  logic              err_q,     err_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q,  wvalid_d;
  logic              bready_q,  bready_d;
  logic [ADDR_W-1:0] awaddr_q,  awaddr_d;
  logic [DATA_W-1:0] wdata_q,   wdata_d;
  logic [STRB_W-1:0] wstrb_q,   wstrb_d;

  align_t align_c;

  ysyx_22040931_store_align u_align (
    .memwop  (bus.in_memwop),
    .off     (bus.in_addr[2:0]),
    .wdata   (bus.in_wdata),
    .align_c (align_c)
  );

  // Next-state and output-register logic; AW and W retire independently in SEND.
  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid && is_store(bus.in_memwop)) begin
          if (align_c.misalign) begin
            state_d = S_ERR;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d   = S_SEND;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = {bus.in_addr[ADDR_W-1:3], 3'b000};
            wdata_d   = align_c.wdata;
            wstrb_d   = align_c.wstrb;
          end
        end
      end
      S_SEND: begin
        if (awvalid_q && bus.awready) awvalid_d = 1'b0;
        if (wvalid_q && bus.wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = S_RESP;
          bready_d = 1'b1;
        end
      end
      S_RESP: begin
        if (bus.bvalid) begin
          state_d  = S_IDLE;
          bready_d = 1'b0;
          done_d   = 1'b1;
          err_d    = (bus.bresp != RESP_OKAY);
        end
      end
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    in_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      in_ready_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      bready_q   <= bready_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.awvalid  = awvalid_q;
  assign bus.awaddr   = awaddr_q;
  assign bus.wvalid   = wvalid_q;
  assign bus.wdata    = wdata_q;
  assign bus.wstrb    = wstrb_q;
  assign bus.bready   = bready_q;

endmodule

// File: tb/tb_ysyx_22040931_store_unit.sv
// Bench for the store unit: directed vector table, random stores against a
// byte-lane reference model, and hand-written reset / back-to-back / illegal-code sequences.
module tb_ysyx_22040931_store_unit;
  import ysyx_22040931_store_unit_pkg::*;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ysyx_22040931_store_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ysyx_22040931_store_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0]  op;
    logic [63:0] addr;
    logic [63:0] data;
    int          aw_dly;
    int          w_dly;
    int          b_dly;
    logic [1:0]  bresp;
    bit          early_b;
    bit          e_bus;
    bit          e_err;
    int          e_lat;
    logic [63:0] e_awaddr;
    logic [63:0] e_wdata;
    logic [7:0]  e_wstrb;
    int          e_awvc;
    int          e_wvc;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  // slave model state
  int aw_dly, w_dly, b_dly;
  logic [1:0] b_resp;
  bit early_b;
  int aw_cnt, w_cnt, b_cnt, aw_hs, w_hs, b_hs, aw_vc, w_vc, unstable;
  bit aw_hold, w_hold;
  logic [63:0] aw_prev, w_prev_d, cap_awaddr, cap_wdata;
  logic [7:0] w_prev_s, cap_wstrb;

  // transaction results
  int r_done_cnt, r_lat;
  bit r_err, r_got_done, r_post_ok;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic slave_cfg(input int a, input int w, input int b, input logic [1:0] r, input bit e);
    aw_dly = a; w_dly = w; b_dly = b; b_resp = r; early_b = e;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
    aw_vc = 0; w_vc = 0; unstable = 0; aw_hold = 0; w_hold = 0;
    cap_awaddr = '0; cap_wdata = '0; cap_wstrb = '0;
  endtask

  // Called at each negedge: checks held payloads, then drives readies/bvalid for the next posedge.
  task automatic slave_step();
    if (aw_hold && (!bus.awvalid || bus.awaddr != aw_prev)) unstable++;
    if (w_hold && (!bus.wvalid || bus.wdata != w_prev_d || bus.wstrb != w_prev_s)) unstable++;
    if (bus.awvalid) aw_vc++;
    if (bus.wvalid)  w_vc++;
    if (early_b) bus.bvalid = 1'b1;
    else if (aw_hs > b_hs && w_hs > b_hs) begin
      bus.bvalid = (b_cnt >= b_dly);
      b_cnt++;
    end else bus.bvalid = 1'b0;
    bus.bresp = b_resp;
    if (bus.bvalid && bus.bready) begin b_hs++; b_cnt = 0; end
    bus.awready = bus.awvalid && (aw_cnt >= aw_dly);
    if (bus.awvalid) begin
      if (bus.awready) begin aw_hs++; cap_awaddr = bus.awaddr; aw_cnt = 0; end
      else aw_cnt++;
    end
    bus.wready = bus.wvalid && (w_cnt >= w_dly);
    if (bus.wvalid) begin
      if (bus.wready) begin w_hs++; cap_wdata = bus.wdata; cap_wstrb = bus.wstrb; w_cnt = 0; end
      else w_cnt++;
    end
    aw_hold = bus.awvalid && !bus.awready; aw_prev = bus.awaddr;
    w_hold = bus.wvalid && !bus.wready; w_prev_d = bus.wdata; w_prev_s = bus.wstrb;
  endtask

  // Presents one store, runs until done (bounded), then one more cycle for the pulse/ready check.
  task automatic run_txn(input logic [2:0] op, input logic [63:0] addr, input logic [63:0] data);
    bit acc = 0;
    int acc_cyc = 0;
    int cyc = 0;
    bus.in_valid = 1'b1; bus.in_memwop = op; bus.in_addr = addr; bus.in_wdata = data;
    r_done_cnt = 0; r_got_done = 0; r_err = 0; r_lat = -1; r_post_ok = 0;
    while (!r_got_done && cyc < 200) begin
      if (bus.done) begin
        r_done_cnt++; r_err = bus.err; r_lat = cyc - acc_cyc; r_got_done = 1;
      end else begin
        if (!acc && bus.in_valid && bus.in_ready) begin acc = 1; acc_cyc = cyc; end
        slave_step();
        @(negedge clk);
        if (acc) bus.in_valid = 1'b0;
        cyc++;
      end
    end
    bus.in_valid = 1'b0;
    slave_step();
    @(negedge clk);
    r_post_ok = !bus.done && bus.in_ready;
    bus.bvalid = 1'b0; bus.awready = 1'b0; bus.wready = 1'b0;
  endtask

  // Reference: byte-lane view of a store, independent of any shift/strobe table.
  function automatic void ref_store(input logic [2:0] op, input logic [63:0] addr,
                                    input logic [63:0] data, output bit mis,
                                    output logic [63:0] ea, output logic [63:0] ed,
                                    output logic [7:0] es);
    int nbytes;
    int off;
    nbytes = (op == W_ONE) ? 1 : (op == W_DOU) ? 2 : (op == W_FOR) ? 4 : 8;
    off = int'(addr % 64'd8);
    mis = (off % nbytes) != 0;
    ea = addr - 64'(off);
    ed = '0;
    es = '0;
    for (int i = 0; i < 8; i++) if (i >= off) ed[8*i +: 8] = data[8*(i-off) +: 8];
    for (int i = 0; i < nbytes; i++) if (off + i < 8) es[off+i] = 1'b1;
  endfunction

  vec_t vecs[9];

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_memwop = '0; bus.in_addr = '0; bus.in_wdata = '0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = '0;
    slave_cfg(0, 0, 0, 2'b00, 0);

    vecs[0] = '{W_ONE, 64'h8000_0003, 64'hAB, 0, 0, 0, 2'b00, 1'b0, 1'b1, 1'b0, 3,
                64'h8000_0000, 64'hAB00_0000, 8'h08, 1, 1};
    vecs[1] = '{W_FOR, 64'h8000_0004, 64'h1122_3344, 4, 0, 0, 2'b00, 1'b0, 1'b1, 1'b0, 7,
                64'h8000_0000, 64'h1122_3344_0000_0000, 8'hF0, 5, 1};
    vecs[2] = '{W_DOU, 64'h8000_0001, 64'h1234, 0, 0, 0, 2'b00, 1'b0, 1'b0, 1'b1, 1,
                64'h0, 64'h0, 8'h00, 0, 0};
    vecs[3] = '{W_EIG, 64'h8000_0000, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 2'b10, 1'b0, 1'b1, 1'b1, 3,
                64'h8000_0000, 64'h0123_4567_89AB_CDEF, 8'hFF, 1, 1};
    vecs[4] = '{W_DOU, 64'h8000_0006, 64'hBEEF, 0, 2, 1, 2'b00, 1'b0, 1'b1, 1'b0, 6,
                64'h8000_0000, 64'hBEEF_0000_0000_0000, 8'hC0, 1, 3};
    vecs[5] = '{W_FOR, 64'h8000_0002, 64'h5566_7788, 0, 0, 0, 2'b00, 1'b0, 1'b0, 1'b1, 1,
                64'h0, 64'h0, 8'h00, 0, 0};
    vecs[6] = '{W_EIG, 64'h8000_0008, 64'h5555_AAAA_5555_AAAA, 1, 3, 0, 2'b00, 1'b1, 1'b1, 1'b0, 6,
                64'h8000_0008, 64'h5555_AAAA_5555_AAAA, 8'hFF, 2, 4};
    vecs[7] = '{W_ONE, 64'h1000_0007, 64'hFFFF_FFFF_FFFF_FF5A, 0, 0, 0, 2'b11, 1'b0, 1'b1, 1'b1, 3,
                64'h1000_0000, 64'h5A00_0000_0000_0000, 8'h80, 1, 1};
    vecs[8] = '{W_EIG, 64'h8000_0004, 64'h1, 0, 0, 0, 2'b00, 1'b0, 1'b0, 1'b1, 1,
                64'h0, 64'h0, 8'h00, 0, 0};

    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_done",     64'(bus.done),     64'd0);
    check("rst_err",      64'(bus.err),      64'd0);
    check("rst_awvalid",  64'(bus.awvalid),  64'd0);
    check("rst_wvalid",   64'(bus.wvalid),   64'd0);
    check("rst_bready",   64'(bus.bready),   64'd0);
    check("rst_awaddr",   bus.awaddr,        64'd0);
    check("rst_wdata",    bus.wdata,         64'd0);
    check("rst_wstrb",    64'(bus.wstrb),    64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vector table
    foreach (vecs[i]) begin
      slave_cfg(vecs[i].aw_dly, vecs[i].w_dly, vecs[i].b_dly, vecs[i].bresp, vecs[i].early_b);
      run_txn(vecs[i].op, vecs[i].addr, vecs[i].data);
      check($sformatf("vec%0d_done_cnt", i), 64'(r_done_cnt), 64'd1);
      check($sformatf("vec%0d_err", i), 64'(r_err), 64'(vecs[i].e_err));
      check($sformatf("vec%0d_latency", i), 64'(r_lat), 64'(vecs[i].e_lat));
      check($sformatf("vec%0d_aw_hs", i), 64'(aw_hs), 64'(vecs[i].e_bus));
      check($sformatf("vec%0d_w_hs", i), 64'(w_hs), 64'(vecs[i].e_bus));
      check($sformatf("vec%0d_awvalid_cycles", i), 64'(aw_vc), 64'(vecs[i].e_awvc));
      check($sformatf("vec%0d_wvalid_cycles", i), 64'(w_vc), 64'(vecs[i].e_wvc));
      check($sformatf("vec%0d_held_payload", i), 64'(unstable), 64'd0);
      check($sformatf("vec%0d_pulse_ready", i), 64'(r_post_ok), 64'd1);
      if (vecs[i].e_bus) begin
        check($sformatf("vec%0d_awaddr", i), cap_awaddr, vecs[i].e_awaddr);
        check($sformatf("vec%0d_wdata", i), cap_wdata, vecs[i].e_wdata);
        check($sformatf("vec%0d_wstrb", i), 64'(cap_wstrb), 64'(vecs[i].e_wstrb));
      end
    end

    // Random stores against the byte-lane reference
    for (int t = 0; t < 40; t++) begin
      logic [2:0] op;
      logic [63:0] addr, data, ea, ed;
      logic [7:0] es;
      logic [1:0] br;
      bit mis;
      int ad, wd, bd, elat;
      op = 3'($urandom_range(1, 4));
      addr = {$urandom, $urandom};
      data = {$urandom, $urandom};
      ad = $urandom_range(0, 3); wd = $urandom_range(0, 3); bd = $urandom_range(0, 2);
      br = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      ref_store(op, addr, data, mis, ea, ed, es);
      elat = mis ? 1 : (((ad > wd) ? ad : wd) + 1 + bd + 1 + 1);
      slave_cfg(ad, wd, bd, br, 0);
      run_txn(op, addr, data);
      check($sformatf("rnd%0d_done_cnt", t), 64'(r_done_cnt), 64'd1);
      check($sformatf("rnd%0d_err", t), 64'(r_err), 64'(mis || (br != 2'b00)));
      check($sformatf("rnd%0d_latency", t), 64'(r_lat), 64'(elat));
      check($sformatf("rnd%0d_aw_hs", t), 64'(aw_hs), 64'(!mis));
      check($sformatf("rnd%0d_held_payload", t), 64'(unstable), 64'd0);
      if (!mis) begin
        check($sformatf("rnd%0d_awaddr", t), cap_awaddr, ea);
        check($sformatf("rnd%0d_wdata", t), cap_wdata, ed);
        check($sformatf("rnd%0d_wstrb", t), 64'(cap_wstrb), 64'(es));
      end
    end

    // Illegal / zero width codes are ignored
    begin
      int bad = 0;
      slave_cfg(0, 0, 0, 2'b00, 0);
      bus.in_valid = 1'b1; bus.in_addr = 64'h8000_0000; bus.in_wdata = 64'hFF;
      for (int c = 0; c < 8; c++) begin
        bus.in_memwop = (c < 2) ? 3'b000 : (c < 4) ? 3'b101 : (c < 6) ? 3'b110 : 3'b111;
        slave_step();
        @(negedge clk);
        if (!bus.in_ready || bus.done || bus.awvalid || bus.wvalid) bad++;
      end
      bus.in_valid = 1'b0;
      check("illegal_code_ignored", 64'(bad), 64'd0);
    end

    // Reset while AW/W are pending
    begin
      int c = 0;
      bit seen_done = 0, seen_valid = 0;
      slave_cfg(50, 50, 0, 2'b00, 0);
      bus.in_valid = 1'b1; bus.in_memwop = W_EIG; bus.in_addr = 64'h8000_0100; bus.in_wdata = 64'h42;
      while (!bus.awvalid && c < 10) begin
        slave_step();
        @(negedge clk);
        bus.in_valid = 1'b0;
        c++;
      end
      check("rst_mid_reached_send", 64'(bus.awvalid), 64'd1);
      rst_n = 1'b0;
      bus.awready = 1'b0; bus.wready = 1'b0;
      @(negedge clk);
      check("rst_mid_awvalid", 64'(bus.awvalid), 64'd0);
      check("rst_mid_wvalid",  64'(bus.wvalid),  64'd0);
      check("rst_mid_in_ready", 64'(bus.in_ready), 64'd1);
      check("rst_mid_done", 64'(bus.done), 64'd0);
      rst_n = 1'b1;
      slave_cfg(0, 0, 0, 2'b00, 0);
      for (int k = 0; k < 5; k++) begin
        slave_step();
        @(negedge clk);
        if (bus.done) seen_done = 1;
        if (bus.awvalid || bus.wvalid || bus.bready) seen_valid = 1;
      end
      check("rst_mid_no_done_after", 64'(seen_done), 64'd0);
      check("rst_mid_no_bus_after", 64'(seen_valid), 64'd0);
    end

    // Back-to-back sd then sb with in_valid held throughout
    begin
      int cyc = 0, acc1 = -1, acc2 = -1, done1 = -1, done2 = -1, ready_bad = 0, n_done = 0;
      bit err2 = 1;
      slave_cfg(0, 0, 0, 2'b00, 0);
      bus.in_valid = 1'b1; bus.in_memwop = W_EIG; bus.in_addr = 64'h8000_0010;
      bus.in_wdata = 64'hDEAD_BEEF_CAFE_F00D;
      while (done2 < 0 && cyc < 100) begin
        if (bus.done) begin
          n_done++;
          if (done1 < 0) done1 = cyc;
          else begin done2 = cyc; err2 = bus.err; end
        end
        if (acc1 >= 0 && cyc > acc1 && done1 < 0 && bus.in_ready) ready_bad++;
        if (bus.in_valid && bus.in_ready) begin
          if (acc1 < 0) acc1 = cyc;
          else if (acc2 < 0) acc2 = cyc;
        end
        slave_step();
        @(negedge clk);
        cyc++;
        if (acc1 >= 0 && acc2 < 0) begin
          bus.in_memwop = W_ONE; bus.in_addr = 64'h8000_0021; bus.in_wdata = 64'h77;
        end
        if (acc2 >= 0) bus.in_valid = 1'b0;
      end
      bus.in_valid = 1'b0; bus.bvalid = 1'b0; bus.awready = 1'b0; bus.wready = 1'b0;
      check("b2b_done_count", 64'(n_done), 64'd2);
      check("b2b_ready_low_while_busy", 64'(ready_bad), 64'd0);
      check("b2b_second_after_first_done", 64'(acc2 >= done1 && done1 >= 0), 64'd1);
      check("b2b_aw_hs", 64'(aw_hs), 64'd2);
      check("b2b_awaddr2", cap_awaddr, 64'h8000_0020);
      check("b2b_wstrb2", 64'(cap_wstrb), 64'h02);
      check("b2b_wdata2", cap_wdata, 64'h7700);
      check("b2b_err2", 64'(err2), 64'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
